datapath_regbank: RTL and testbench
===================================

Name: datapath_regbank

Overview:
- Register-file and bus datapath driven directly by the processor control FSM's alu_op, read_en, write_en and inc_en outputs.
- Contains the single shared bus mux, the architectural registers, the ALU and the zero flag.
- Drives the instruction-memory and data-memory address/data ports.
- Returns instruction and z to the control FSM.

Parameters:
- WIDTH, 16, width of bus, all registers, ALU and memory data.
- ADDR_W, 16, width of im_addr/dm_addr; low ADDR_W bits of PC/DAR.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high; clears all state.
- alu_op  input  3  0 none, 1 add, 2 sub, 3 lshift, 4 rshift; others give result 0.
- read_en  input  4  bus source select.
- write_en  input  16  one-hot-per-bit register load enables.
- inc_en  input  16  per-bit register increment enables.
- im_rdata  input  WIDTH  instruction memory read data.
- dm_rdata  input  WIDTH  data memory read data.
- im_addr  output  ADDR_W  = PC.
- dm_addr  output  ADDR_W  = DAR.
- dm_wdata  output  WIDTH  = AC.
- dm_we  output  1  = write_en[12], combinational.
- instruction  output  WIDTH  = IR.
- z  output  WIDTH  {WIDTH-1 zeros, ZF}.
- bus  output  WIDTH  current bus value (debug/observe).

Behaviour:
- Registers: PC, DAR, IR, AC, R, R1..R5 (all WIDTH), ZF (1 bit). All clear to 0 asynchronously on reset. Outputs follow registers, so every output is 0 during reset (dm_we follows write_en).
- Bus mux (combinational) by read_en:
  - 2 = DAR, 5 = AC, 6 = R, 7..11 = R1..R5.
  - 12 = dm_rdata, 13 = im_rdata.
  - Any other value = 0.
- write_en mapping (load from bus at posedge):
  - bit1 PC, bit2 DAR, bit4 IR, bit5 AC.
  - bit6 R, bit7..11 R1..R5.
  - bit12 external memory write only.
  - bit15 AC <= ALU result; bit14 ZF <= (ALU result == 0).
  - Unused bits (0, 3, 13) are ignored.
- inc_en mapping (+1 modulo 2^WIDTH at posedge):
  - bit1 PC, bit2 AC, bit3 DAR.
  - bit4 R1, bit5 R2, bit6 R3.
  - Other bits are ignored.
- ALU (combinational): A = AC, B = R.
  - add A+B; sub A-B.
  - lshift A<<1; rshift A>>1 (logical).
  - Result truncated to WIDTH; carry/borrow discarded.
- Per-register priority within a cycle: ALU write (bit15) > bus write > increment > hold. Example: write_en[1] and inc_en[1] together load PC from bus with no increment.
- All enabled updates in one cycle occur in parallel. Each register samples pre-edge values, so AC on bus with write_en[2] and inc_en[2] gives DAR = old AC and AC = old AC+1.
- ZF changes only when write_en[14] is set; otherwise it holds.
- Latency:
  - Bus and ALU are zero-cycle combinational.
  - Register updates are visible one cycle after the enable.
  - Memories are external with one-cycle read latency, so the FSM holds read_en 12/13 for two states and loads on the second.
- Wrap-around: PC, DAR, AC and R1..R3 at all-ones increment to 0; ZF is not affected by increments.
- Reset asserted mid-instruction clears state immediately. The first posedge after deassertion applies whatever enables are present.

Test Plan:
- Reset: assert reset with write_en = 16'hFFFF -> all registers, ZF, im_addr, dm_addr, instruction read 0; after release with enables 0, registers stay 0.
- Fetch: PC = 0, im_rdata = 16'h0021, read_en = 13, write_en = 16'h0010 for 2 cycles -> instruction = 16'h0021; bus = 16'h0021 during both cycles.
- Load via memory: AC = 16'h0040, read_en = 5, write_en[2] -> dm_addr = 16'h0040. Then dm_rdata = 16'h1234, read_en = 12, write_en[5] -> AC = 16'h1234.
- ALU sub to zero: AC = 16'h0007, R = 16'h0007, alu_op = 2, write_en = 16'hC000 -> AC = 0, ZF = 1, z = 16'h0001. Then alu_op = 1 with R = 1, write_en = 16'hC000 -> AC = 1, z = 0.
- Priority/wrap: PC = 16'hFFFF with inc_en[1] -> PC = 0. Then read_en = 13, im_rdata = 16'h0055, write_en[1] and inc_en[1] together -> PC = 16'h0055.
- Store + shifts: AC = 16'h8001, write_en[12] -> dm_we = 1 same cycle, dm_wdata = 16'h8001. lshift -> AC = 16'h0002; rshift -> AC = 16'h0001.

Source files
------------

// File: rtl/datapath_regbank.sv
// -----------------------------------------------------------------------------
// datapath_regbank
//
// Register-file and shared-bus datapath for a small accumulator processor.
// The control FSM drives alu_op / read_en / write_en / inc_en directly. This
// block holds the architectural registers (PC, DAR, IR, AC, R, R1..R5), the
// zero flag, the single bus mux and the ALU. It drives the instruction-memory
// and data-memory ports, and it returns the instruction and the zero flag to
// the FSM.
//
// Ports
//   clock        rising-edge clock
//   reset        asynchronous, active-high; clears every register and ZF
//   alu_op[2:0]  0 none, 1 add, 2 sub, 3 lshift, 4 rshift (others: result 0)
//   read_en[3:0] bus source select (2 DAR, 5 AC, 6 R, 7..11 R1..R5,
//                12 dm_rdata, 13 im_rdata, anything else 0)
//   write_en[15:0] per-register load enables (see WE_* below)
//   inc_en[15:0]   per-register increment enables (see INC_* below)
//   im_rdata     instruction memory read data
//   dm_rdata     data memory read data
//   im_addr      = PC (low ADDR_W bits)
//   dm_addr      = DAR (low ADDR_W bits)
//   dm_wdata     = AC
//   dm_we        = write_en[12], combinational pass-through
//   instruction  = IR
//   z            = {zeros, ZF}
//   bus          current bus value, for observation
//
// Per-register update priority in a cycle: ALU write > bus write > increment
// > hold. Every register samples pre-edge values, so all updates in a cycle
// happen in parallel. ADDR_W is expected to be no larger than WIDTH.
// -----------------------------------------------------------------------------
module datapath_regbank #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [2:0]        alu_op,
    input  logic [3:0]        read_en,
    input  logic [15:0]       write_en,
    input  logic [15:0]       inc_en,
    input  logic [WIDTH-1:0]  im_rdata,
    input  logic [WIDTH-1:0]  dm_rdata,
    output logic [ADDR_W-1:0] im_addr,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [WIDTH-1:0]  dm_wdata,
    output logic              dm_we,
    output logic [WIDTH-1:0]  instruction,
    output logic [WIDTH-1:0]  z,
    output logic [WIDTH-1:0]  bus
);

    // Bus source codes
    localparam logic [3:0] RD_DAR = 4'd2;
    localparam logic [3:0] RD_AC  = 4'd5;
    localparam logic [3:0] RD_R   = 4'd6;
    localparam logic [3:0] RD_R1  = 4'd7;
    localparam logic [3:0] RD_R2  = 4'd8;
    localparam logic [3:0] RD_R3  = 4'd9;
    localparam logic [3:0] RD_R4  = 4'd10;
    localparam logic [3:0] RD_R5  = 4'd11;
    localparam logic [3:0] RD_DM  = 4'd12;
    localparam logic [3:0] RD_IM  = 4'd13;

    // write_en bit positions
    localparam int WE_PC  = 1;
    localparam int WE_DAR = 2;
    localparam int WE_IR  = 4;
    localparam int WE_AC  = 5;
    localparam int WE_R   = 6;
    localparam int WE_R1  = 7;
    localparam int WE_R2  = 8;
    localparam int WE_R3  = 9;
    localparam int WE_R4  = 10;
    localparam int WE_R5  = 11;
    localparam int WE_DM  = 12;
    localparam int WE_ZF  = 14;
    localparam int WE_ALU = 15;

    // inc_en bit positions
    localparam int INC_PC  = 1;
    localparam int INC_AC  = 2;
    localparam int INC_DAR = 3;
    localparam int INC_R1  = 4;
    localparam int INC_R2  = 5;
    localparam int INC_R3  = 6;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    typedef enum logic [2:0] {
        ALU_NONE = 3'd0,
        ALU_ADD  = 3'd1,
        ALU_SUB  = 3'd2,
        ALU_LSH  = 3'd3,
        ALU_RSH  = 3'd4
    } alu_op_e;

    logic [WIDTH-1:0] pc_q,  pc_d;
    logic [WIDTH-1:0] dar_q, dar_d;
    logic [WIDTH-1:0] ir_q,  ir_d;
    logic [WIDTH-1:0] ac_q,  ac_d;
    logic [WIDTH-1:0] r_q,   r_d;
    logic [WIDTH-1:0] r1_q,  r1_d;
    logic [WIDTH-1:0] r2_q,  r2_d;
    logic [WIDTH-1:0] r3_q,  r3_d;
    logic [WIDTH-1:0] r4_q,  r4_d;
    logic [WIDTH-1:0] r5_q,  r5_d;
    logic             zf_q,  zf_d;

    logic [WIDTH-1:0] bus_val;
    logic [WIDTH-1:0] alu_res;

    // Enable bits with no function in this datapath; gathered so they are
    // visibly consumed rather than silently dropped.
    logic unused_en;
    assign unused_en = ^{write_en[0], write_en[3], write_en[13],
                         inc_en[0], inc_en[15:7]};

    // ---------------------------------------------------------------- bus mux
    always_comb begin
        bus_val = '0;
        case (read_en)
            RD_DAR:  bus_val = dar_q;
            RD_AC:   bus_val = ac_q;
            RD_R:    bus_val = r_q;
            RD_R1:   bus_val = r1_q;
            RD_R2:   bus_val = r2_q;
            RD_R3:   bus_val = r3_q;
            RD_R4:   bus_val = r4_q;
            RD_R5:   bus_val = r5_q;
            RD_DM:   bus_val = dm_rdata;
            RD_IM:   bus_val = im_rdata;
            default: bus_val = '0;
        endcase
    end

    // -------------------------------------------------------------------- ALU
    // Operands are fixed: A = AC, B = R. Carry and borrow fall off the top.
    always_comb begin
        alu_res = '0;
        case (alu_op)
            ALU_ADD:  alu_res = ac_q + r_q;
            ALU_SUB:  alu_res = ac_q - r_q;
            ALU_LSH:  alu_res = ac_q << 1;
            ALU_RSH:  alu_res = ac_q >> 1;
            ALU_NONE: alu_res = '0;
            default:  alu_res = '0;
        endcase
    end

    // ------------------------------------------------------ next-state logic
    always_comb begin
        pc_d  = pc_q;
        dar_d = dar_q;
        ir_d  = ir_q;
        ac_d  = ac_q;
        r_d   = r_q;
        r1_d  = r1_q;
        r2_d  = r2_q;
        r3_d  = r3_q;
        r4_d  = r4_q;
        r5_d  = r5_q;
        zf_d  = zf_q;

        // A bus load wins over an increment on the same register.
        if (write_en[WE_PC])        pc_d = bus_val;
        else if (inc_en[INC_PC])    pc_d = pc_q + ONE;

        if (write_en[WE_DAR])       dar_d = bus_val;
        else if (inc_en[INC_DAR])   dar_d = dar_q + ONE;

        if (write_en[WE_IR])        ir_d = bus_val;

        // AC is the only register the ALU writes; that path outranks the bus.
        if (write_en[WE_ALU])       ac_d = alu_res;
        else if (write_en[WE_AC])   ac_d = bus_val;
        else if (inc_en[INC_AC])    ac_d = ac_q + ONE;

        if (write_en[WE_R])         r_d = bus_val;

        if (write_en[WE_R1])        r1_d = bus_val;
        else if (inc_en[INC_R1])    r1_d = r1_q + ONE;

        if (write_en[WE_R2])        r2_d = bus_val;
        else if (inc_en[INC_R2])    r2_d = r2_q + ONE;

        if (write_en[WE_R3])        r3_d = bus_val;
        else if (inc_en[INC_R3])    r3_d = r3_q + ONE;

        if (write_en[WE_R4])        r4_d = bus_val;
        if (write_en[WE_R5])        r5_d = bus_val;

        // ZF reflects the ALU result of the cycle it is loaded in, and is
        // otherwise untouched (increments never change it).
        if (write_en[WE_ZF])        zf_d = (alu_res == '0);
    end

    // -------------------------------------------------------------- registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q  <= '0;
            dar_q <= '0;
            ir_q  <= '0;
            ac_q  <= '0;
            r_q   <= '0;
            r1_q  <= '0;
            r2_q  <= '0;
            r3_q  <= '0;
            r4_q  <= '0;
            r5_q  <= '0;
            zf_q  <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            dar_q <= dar_d;
            ir_q  <= ir_d;
            ac_q  <= ac_d;
            r_q   <= r_d;
            r1_q  <= r1_d;
            r2_q  <= r2_d;
            r3_q  <= r3_d;
            r4_q  <= r4_d;
            r5_q  <= r5_d;
            zf_q  <= zf_d;
        end
    end

    // ---------------------------------------------------------------- outputs
    assign im_addr     = pc_q[ADDR_W-1:0];
    assign dm_addr     = dar_q[ADDR_W-1:0];
    assign dm_wdata    = ac_q;
    assign dm_we       = write_en[WE_DM];
    assign instruction = ir_q;
    assign z           = {{(WIDTH-1){1'b0}}, zf_q};
    assign bus         = bus_val;

endmodule

// File: tb/tb_datapath_regbank.sv
// -----------------------------------------------------------------------------
// tb_datapath_regbank
//
// Directed scenarios followed by randomized cycles. A behavioural model holds
// the register contents in a small array, uses lookup tables for the bus
// source and the enable-bit mapping, and computes ALU results with plain
// integer arithmetic. Every cycle the bench compares all observable outputs
// against the model; directed scenarios add fixed expected constants.
// -----------------------------------------------------------------------------
module tb_datapath_regbank;

    localparam int W = 16;

    // ------------------------------------------------------------ clock/reset
    logic          clock = 1'b0;
    logic          reset;
    logic [2:0]    alu_op;
    logic [3:0]    read_en;
    logic [15:0]   write_en;
    logic [15:0]   inc_en;
    logic [W-1:0]  im_rdata;
    logic [W-1:0]  dm_rdata;
    logic [W-1:0]  im_addr;
    logic [W-1:0]  dm_addr;
    logic [W-1:0]  dm_wdata;
    logic          dm_we;
    logic [W-1:0]  instruction;
    logic [W-1:0]  z;
    logic [W-1:0]  bus;

    always #5 clock = ~clock;

    datapath_regbank #(.WIDTH(W), .ADDR_W(W)) dut (
        .clock       (clock),
        .reset       (reset),
        .alu_op      (alu_op),
        .read_en     (read_en),
        .write_en    (write_en),
        .inc_en      (inc_en),
        .im_rdata    (im_rdata),
        .dm_rdata    (dm_rdata),
        .im_addr     (im_addr),
        .dm_addr     (dm_addr),
        .dm_wdata    (dm_wdata),
        .dm_we       (dm_we),
        .instruction (instruction),
        .z           (z),
        .bus         (bus)
    );

    // ------------------------------------------------------- reference model
    // Register index: 0 PC, 1 DAR, 2 IR, 3 AC, 4 R, 5..9 R1..R5
    logic [W-1:0] mr [10];
    logic         mzf;

    // read_en -> register index, 10 = dm_rdata, 11 = im_rdata, -1 = zero
    int src_of [16] = '{-1, -1, 1, -1, -1, 3, 4, 5, 6, 7, 8, 9, 10, 11, -1, -1};
    // register index -> write_en bit
    int wr_bit [10] = '{1, 2, 4, 5, 6, 7, 8, 9, 10, 11};
    // register index -> inc_en bit (0 = register has no increment)
    int inc_bit[10] = '{1, 3, 0, 2, 0, 4, 5, 6, 0, 0};

    logic [W-1:0] exp_q [$];

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [W-1:0] obs,
                         input logic [W-1:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 10; i++) mr[i] = '0;
        mzf = 1'b0;
    endtask

    function automatic logic [W-1:0] model_bus(input logic [3:0] rd,
                                               input logic [W-1:0] im,
                                               input logic [W-1:0] dm);
        int s;
        s = src_of[rd];
        if (s < 0)        return '0;
        else if (s == 10) return dm;
        else if (s == 11) return im;
        else              return mr[s];
    endfunction

    function automatic logic [W-1:0] model_alu(input logic [2:0] op);
        int a, b, r;
        a = int'(mr[3]);
        b = int'(mr[4]);
        case (op)
            3'd1:    r = a + b;
            3'd2:    r = a - b;
            3'd3:    r = a * 2;
            3'd4:    r = a / 2;
            default: r = 0;
        endcase
        return W'(r & 32'h0000_FFFF);
    endfunction

    task automatic model_step(input logic [15:0] we, input logic [15:0] inc,
                              input logic [2:0] op, input logic [W-1:0] busv);
        logic [W-1:0] nxt [10];
        logic [W-1:0] alu;
        alu = model_alu(op);
        for (int i = 0; i < 10; i++) begin
            nxt[i] = mr[i];
            if (i == 3 && we[15])                      nxt[i] = alu;
            else if (we[wr_bit[i]])                    nxt[i] = busv;
            else if (inc_bit[i] > 0 && inc[inc_bit[i]]) nxt[i] = mr[i] + 16'd1;
        end
        if (we[14]) mzf = (alu == 16'd0);
        for (int i = 0; i < 10; i++) mr[i] = nxt[i];
    endtask

    // ---------------------------------------------------------------- driver
    // Inputs change on the falling edge; outputs are compared 1 time unit
    // later, and the model then advances to the state after the next rise.
    task automatic drive(input logic rst_v, input logic [3:0] rd,
                         input logic [15:0] we, input logic [15:0] inc,
                         input logic [2:0] op, input logic [W-1:0] im,
                         input logic [W-1:0] dm);
        logic [W-1:0] exp_bus;
        @(negedge clock);
        reset    = rst_v;
        read_en  = rd;
        write_en = we;
        inc_en   = inc;
        alu_op   = op;
        im_rdata = im;
        dm_rdata = dm;
        #1;
        if (rst_v) model_clear();
        exp_bus = model_bus(rd, im, dm);
        exp_q.push_back(exp_bus);
        check("bus",         bus,         exp_q.pop_front());
        check("im_addr",     im_addr,     mr[0]);
        check("dm_addr",     dm_addr,     mr[1]);
        check("instruction", instruction, mr[2]);
        check("dm_wdata",    dm_wdata,    mr[3]);
        check("z",           z,           {15'd0, mzf});
        check("dm_we",       {15'd0, dm_we}, {15'd0, we[12]});
        if (!rst_v) model_step(we, inc, op, exp_bus);
    endtask

    task automatic cyc(input logic [3:0] rd, input logic [15:0] we,
                       input logic [15:0] inc, input logic [2:0] op,
                       input logic [W-1:0] im, input logic [W-1:0] dm);
        drive(1'b0, rd, we, inc, op, im, dm);
    endtask

    task automatic after_edge();
        @(posedge clock);
        #1;
    endtask

    // -------------------------------------------------------------- stimulus
    initial begin
        reset    = 1'b1;
        alu_op   = 3'd0;
        read_en  = 4'd5;
        write_en = 16'hFFFF;
        inc_en   = 16'hFFFF;
        im_rdata = 16'hAAAA;
        dm_rdata = 16'h5555;
        model_clear();

        // Reset with every enable high: state must stay cleared.
        repeat (2) @(posedge clock);
        #1;
        check("rst_im_addr",     im_addr,     16'h0000);
        check("rst_dm_addr",     dm_addr,     16'h0000);
        check("rst_instruction", instruction, 16'h0000);
        check("rst_dm_wdata",    dm_wdata,    16'h0000);
        check("rst_z",           z,           16'h0000);
        check("rst_bus",         bus,         16'h0000);
        check("rst_dm_we",       {15'd0, dm_we}, 16'h0001);

        // Release with enables idle.
        cyc(4'd0, 16'h0000, 16'h0000, 3'd0, 16'h0000, 16'h0000);
        after_edge();
        check("post_rst_pc", im_addr,  16'h0000);
        check("post_rst_ac", dm_wdata, 16'h0000);

        // Fetch: two states with im_rdata on the bus, IR loads.
        cyc(4'd13, 16'h0010, 16'h0000, 3'd0, 16'h0021, 16'h0000);
        cyc(4'd13, 16'h0010, 16'h0000, 3'd0, 16'h0021, 16'h0000);
        check("fetch_bus", bus, 16'h0021);
        after_edge();
        check("fetch_ir", instruction, 16'h0021);

        // Load via memory.
        cyc(4'd13, 16'h0020, 16'h0000, 3'd0, 16'h0040, 16'h0000);  // AC = 0x40
        cyc(4'd5,  16'h0004, 16'h0000, 3'd0, 16'h0000, 16'h0000);  // DAR = AC
        after_edge();
        check("load_dm_addr", dm_addr, 16'h0040);
        cyc(4'd12, 16'h0020, 16'h0000, 3'd0, 16'h0000, 16'h1234);  // AC = dm
        after_edge();
        check("load_ac", dm_wdata, 16'h1234);

        // ALU subtract to zero, then add.
        cyc(4'd13, 16'h0020, 16'h0000, 3'd0, 16'h0007, 16'h0000);  // AC = 7
        cyc(4'd13, 16'h0040, 16'h0000, 3'd0, 16'h0007, 16'h0000);  // R = 7
        cyc(4'd0,  16'hC000, 16'h0000, 3'd2, 16'h0000, 16'h0000);
        after_edge();
        check("sub_ac", dm_wdata, 16'h0000);
        check("sub_z",  z,        16'h0001);
        cyc(4'd13, 16'h0040, 16'h0000, 3'd0, 16'h0001, 16'h0000);  // R = 1
        cyc(4'd0,  16'hC000, 16'h0000, 3'd1, 16'h0000, 16'h0000);
        after_edge();
        check("add_ac", dm_wdata, 16'h0001);
        check("add_z",  z,        16'h0000);

        // Parallel update: DAR takes old AC while AC increments.
        cyc(4'd5, 16'h0004, 16'h0004, 3'd0, 16'h0000, 16'h0000);
        after_edge();
        check("par_dar", dm_addr,  16'h0001);
        check("par_ac",  dm_wdata, 16'h0002);

        // PC wrap, then bus load beating increment.
        cyc(4'd13, 16'h0002, 16'h0000, 3'd0, 16'hFFFF, 16'h0000);
        cyc(4'd0,  16'h0000, 16'h0002, 3'd0, 16'h0000, 16'h0000);
        after_edge();
        check("pc_wrap", im_addr, 16'h0000);
        cyc(4'd13, 16'h0002, 16'h0002, 3'd0, 16'h0055, 16'h0000);
        after_edge();
        check("pc_prio", im_addr, 16'h0055);

        // Store and shifts.
        cyc(4'd13, 16'h0020, 16'h0000, 3'd0, 16'h8001, 16'h0000);  // AC = 0x8001
        cyc(4'd0,  16'h1000, 16'h0000, 3'd0, 16'h0000, 16'h0000);
        check("store_we",    {15'd0, dm_we}, 16'h0001);
        check("store_wdata", dm_wdata,       16'h8001);
        cyc(4'd0, 16'h8000, 16'h0000, 3'd3, 16'h0000, 16'h0000);
        after_edge();
        check("lshift_ac", dm_wdata, 16'h0002);
        cyc(4'd0, 16'h8000, 16'h0000, 3'd4, 16'h0000, 16'h0000);
        after_edge();
        check("rshift_ac", dm_wdata, 16'h0001);

        // AC wrap by increment leaves ZF alone (ZF is 0 here).
        cyc(4'd13, 16'h0020, 16'h0000, 3'd0, 16'hFFFF, 16'h0000);
        cyc(4'd0,  16'h0000, 16'h0004, 3'd0, 16'h0000, 16'h0000);
        after_edge();
        check("ac_wrap",   dm_wdata, 16'h0000);
        check("ac_wrap_z", z,        16'h0000);

        // Randomized traffic with occasional mid-run resets.
        for (int n = 0; n < 3000; n++) begin
            logic        rv;
            logic [15:0] we_r, inc_r;
            rv    = ($urandom_range(0, 199) == 0);
            we_r  = 16'($urandom);
            inc_r = 16'($urandom);
            // Thin out the writes so registers live long enough to be read.
            if ($urandom_range(0, 1) == 0) we_r = we_r & 16'($urandom);
            drive(rv, 4'($urandom_range(0, 15)), we_r, inc_r,
                  3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom));
        end

        cyc(4'd0, 16'h0000, 16'h0000, 3'd0, 16'h0000, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
